// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM access arbiter: FSM state encoding,
// default bus widths and the write-interleave interval.
package vram_pkg;

  localparam int BW_ADDR          = 18;
  localparam int BW_DATA          = 15;
  localparam int BW_LEN           = 9;
  localparam int WBUF_LG2         = 2;
  localparam int INTERLEAVE_WORDS = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ADDR   = 3'd1,
    ST_RD_SAMPLE = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_WR_HOLD   = 3'd5,
    ST_TURN      = 3'd6
  } vram_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write-buffer FIFO. Exposes the head entry and the entry behind it
// so the arbiter can chain back-to-back writes without an idle cycle.
module vram_wr_fifo #(
  parameter int width = 33,
  parameter int lg2   = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [width-1:0] i_data,
  output logic [width-1:0] o_head,
  output logic [width-1:0] o_head_nxt,
  output logic [lg2:0]     o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam int          DEPTH   = 2**lg2;
  localparam logic [lg2:0] DEPTH_C = (lg2+1)'(DEPTH);

  logic [width-1:0] r_mem [DEPTH];
  logic [lg2-1:0]   r_wr_ptr;
  logic [lg2-1:0]   r_rd_ptr;
  logic [lg2:0]     r_count;
  logic [lg2:0]     w_count_nxt;
  logic             r_full;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & (r_count != {(lg2+1){1'b0}});

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (lg2+1)'(1);
      2'b01:   w_count_nxt = r_count - (lg2+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= {lg2{1'b0}};
      r_rd_ptr <= {lg2{1'b0}};
      r_count  <= {(lg2+1){1'b0}};
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + lg2'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + lg2'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
    end
  end

  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head     = r_mem[r_rd_ptr];
  assign o_head_nxt = r_mem[r_rd_ptr + lg2'(1)];
  assign o_count    = r_count;
  assign o_full     = r_full;
  assign o_empty    = (r_count == {(lg2+1){1'b0}});

endmodule

// File: rtl/vram_access_arbiter.sv
// Arbitrates the frame-buffer SRAM between burst reads (priority) and buffered
// single-word writes. Define WR_INTERLEAVE_EN to insert writes into long bursts.
module vram_access_arbiter
  import vram_pkg::*;
#(
  parameter int bw_addr  = BW_ADDR,
  parameter int bw_data  = BW_DATA,
  parameter int bw_len   = BW_LEN,
  parameter int wbuf_lg2 = WBUF_LG2
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               RdReq,
  input  logic [bw_addr-1:0] RdAddr,
  input  logic [bw_len-1:0]  RdLen,
  output logic               RdBusy,
  output logic [bw_data-1:0] RdData,
  output logic               RdValid,
  input  logic               WrReq,
  input  logic [bw_addr-1:0] WrAddr,
  input  logic [bw_data-1:0] WrData,
  output logic               WrReady,
  output logic               nWE,
  output logic               nOE,
  output logic [bw_addr-1:0] SRAMAddr,
  inout  wire  [bw_data-1:0] SRAMIO
);

  localparam int EW = bw_addr + bw_data;

  vram_state_e        r_state;
  logic               r_nwe, r_noe, r_io_oe, r_rd_busy, r_rd_valid;
  logic [bw_addr-1:0] r_sram_addr, r_rd_addr, w_rd_addr_inc;
  logic [bw_data-1:0] r_wr_data, r_rd_data;
  logic [bw_len-1:0]  r_rd_cnt, w_cnt_dec;
  logic               w_accept, w_pending, w_push, w_pop, w_full, w_empty;
  logic               w_more, w_interleave;
  logic [EW-1:0]      w_wr_entry, w_head, w_head_nxt, w_next_entry;
  logic [wbuf_lg2:0]  w_count;

  assign w_accept      = RdReq & (RdLen != {bw_len{1'b0}}) & ~r_rd_busy;
  assign w_pending     = r_rd_busy | w_accept;
  assign w_push        = WrReq & ~w_full;
  assign w_pop         = (r_state == ST_WR_HOLD);
  assign w_wr_entry    = {WrAddr, WrData};
  assign w_rd_addr_inc = r_rd_addr + bw_addr'(1);
  assign w_cnt_dec     = r_rd_cnt - bw_len'(1);
  // Entry that follows the one being popped; may be arriving this very cycle.
  assign w_more        = (w_count > (wbuf_lg2+1)'(1)) | w_push;
  assign w_next_entry  = (w_count > (wbuf_lg2+1)'(1)) ? w_head_nxt : w_wr_entry;

  vram_wr_fifo #(.width(EW), .lg2(wbuf_lg2)) u_wr_fifo (
    .Clock      (Clock),
    .Reset      (Reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_data     (w_wr_entry),
    .o_head     (w_head),
    .o_head_nxt (w_head_nxt),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

`ifdef WR_INTERLEAVE_EN
  logic [4:0] r_run;

  assign w_interleave = (r_run == 5'(INTERLEAVE_WORDS - 1)) & w_full;

  // Consecutive read words since the burst started or the last inserted write.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_run <= 5'd0;
    end else if (r_state == ST_RD_SAMPLE) begin
      if ((w_cnt_dec == {bw_len{1'b0}}) || w_interleave) r_run <= 5'd0;
      else if (r_run != 5'(INTERLEAVE_WORDS - 1))        r_run <= r_run + 5'd1;
      else                                               r_run <= r_run;
    end else begin
      r_run <= r_run;
    end
  end
`else
  assign w_interleave = 1'b0;
`endif

  // Access sequencer; every SRAM-facing strobe is registered on the transition.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_nwe       <= 1'b1;
      r_noe       <= 1'b1;
      r_io_oe     <= 1'b0;
      r_sram_addr <= {bw_addr{1'b0}};
      r_wr_data   <= {bw_data{1'b0}};
      r_rd_data   <= {bw_data{1'b0}};
      r_rd_valid  <= 1'b0;
      r_rd_busy   <= 1'b0;
      r_rd_addr   <= {bw_addr{1'b0}};
      r_rd_cnt    <= {bw_len{1'b0}};
    end else begin
      r_rd_valid <= 1'b0;
      if (w_accept) begin
        r_rd_busy <= 1'b1;
        r_rd_addr <= RdAddr;
        r_rd_cnt  <= RdLen;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pending) begin
            r_state     <= ST_RD_ADDR;
            r_sram_addr <= r_rd_busy ? r_rd_addr : RdAddr;
            r_noe       <= 1'b0;
          end else if (!w_empty) begin
            r_state     <= ST_WR_SETUP;
            r_sram_addr <= w_head[EW-1:bw_data];
            r_wr_data   <= w_head[bw_data-1:0];
            r_io_oe     <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD_ADDR: r_state <= ST_RD_SAMPLE;
        ST_RD_SAMPLE: begin
          r_rd_data  <= SRAMIO;
          r_rd_valid <= 1'b1;
          r_rd_addr  <= w_rd_addr_inc;
          r_rd_cnt   <= w_cnt_dec;
          if (w_cnt_dec == {bw_len{1'b0}}) begin
            r_rd_busy <= 1'b0;
            r_noe     <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (w_interleave) begin
            r_noe       <= 1'b1;
            r_state     <= ST_WR_SETUP;
            r_sram_addr <= w_head[EW-1:bw_data];
            r_wr_data   <= w_head[bw_data-1:0];
            r_io_oe     <= 1'b1;
          end else begin
            r_state     <= ST_RD_ADDR;
            r_sram_addr <= w_rd_addr_inc;
          end
        end
        ST_WR_SETUP: begin
          r_nwe   <= 1'b0;
          r_state <= ST_WR_STROBE;
        end
        ST_WR_STROBE: begin
          r_nwe   <= 1'b1;
          r_state <= ST_WR_HOLD;
        end
        ST_WR_HOLD: begin
          if (w_pending) begin
            r_io_oe <= 1'b0;
            r_state <= ST_TURN;
          end else if (w_more) begin
            r_sram_addr <= w_next_entry[EW-1:bw_data];
            r_wr_data   <= w_next_entry[bw_data-1:0];
            r_state     <= ST_WR_SETUP;
          end else begin
            r_io_oe <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_TURN: begin
          r_sram_addr <= r_rd_addr;
          r_noe       <= 1'b0;
          r_state     <= ST_RD_ADDR;
        end
        default: begin
          r_nwe   <= 1'b1;
          r_noe   <= 1'b1;
          r_io_oe <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign nWE      = r_nwe;
  assign nOE      = r_noe;
  assign SRAMAddr = r_sram_addr;
  assign SRAMIO   = r_io_oe ? r_wr_data : {bw_data{1'bz}};
  assign RdData   = r_rd_data;
  assign RdValid  = r_rd_valid;
  assign RdBusy   = r_rd_busy;
  assign WrReady  = ~w_full;

endmodule

// File: doc/vram_access_arbiter.md
Name: vram_access_arbiter

Overview:
Shares the single external asynchronous SRAM (frame buffer) between two requesters. The display line loader issues high-priority burst reads; the spectrum writer issues low-priority single-word writes through a small write buffer. The block sits between the spectrum writer / display loader and the SRAM pins. It owns nWE, nOE, the SRAM address and the IO tristate.

Parameters:
bw_addr, 18, SRAM address width
bw_data, 15, SRAM data width (RGB555)
bw_len, 9, burst length counter width
wbuf_lg2, 2, log2 of write buffer depth (default 4 entries)

Ports:
Clock  in  1  system clock (PLLClock domain)
Reset  in  1  asynchronous, active-high reset
RdReq  in  1  start display burst; sampled only while RdBusy=0
RdAddr  in  bw_addr  burst start address
RdLen  in  bw_len  burst word count; 0 = no-op
RdBusy  out  1  burst accepted and not yet complete
RdData  out  bw_data  read word
RdValid  out  1  one-cycle strobe per RdData word
WrReq  in  1  write request; accepted when WrReq & WrReady
WrAddr  in  bw_addr  write address
WrData  in  bw_data  write data
WrReady  out  1  write buffer not full (registered)
nWE  out  1  SRAM write enable, active low
nOE  out  1  SRAM output enable, active low
SRAMAddr  out  bw_addr  SRAM address
SRAMIO  inout  bw_data  SRAM data bus; driven only in write states

Behaviour:
- Reset (async): nWE=1, nOE=1, SRAMAddr=0, SRAMIO=Z, RdData=0, RdValid=0, RdBusy=0, WrReady=1, buffer empty, state IDLE. Assertion mid-access aborts immediately; nWE rises asynchronously and the buffered writes are discarded.
- FSM states: IDLE, RD_ADDR, RD_SAMPLE, WR_SETUP, WR_STROBE, WR_HOLD, TURN.
- IDLE:
  - A pending burst goes to RD_ADDR. The burst has priority over a non-empty buffer.
  - Otherwise a non-empty buffer goes to WR_SETUP.
  - Otherwise the FSM stays in IDLE.
- Read, 2 cycles per word:
  - RD_ADDR: drive SRAMAddr = burst address, nOE=0.
  - RD_SAMPLE: register SRAMIO into RdData; RdValid=1 on the following cycle; address +1, remaining count -1.
  - If the count is not yet 0, return to RD_ADDR. nOE stays 0 for the whole burst.
  - When the count reaches 0: RdBusy falls with the last RdValid, nOE=1, go to IDLE.
- Write, 3 cycles per word:
  - WR_SETUP: nOE=1, drive address and data, nWE=1.
  - WR_STROBE: nWE=0.
  - WR_HOLD: nWE=1, address and data still driven; pop the buffer.
  - Next state is TURN if a burst is pending. Otherwise WR_SETUP if the buffer is non-empty, else IDLE.
- TURN: 1 cycle; SRAMIO=Z, nOE=1, nWE=1; then RD_ADDR. This prevents bus contention on write-to-read turnaround.
- Burst acceptance:
  - RdReq with RdLen≠0 while RdBusy=0 latches RdAddr and RdLen and sets RdBusy=1 on the next cycle.
  - A burst accepted during a write completes that write first, including WR_HOLD and TURN.
  - RdReq while RdBusy=1 is ignored. RdLen=0 is ignored and RdBusy stays 0.
- Address wrap: the burst address increments modulo 2^bw_addr.
- Write buffer:
  - FIFO, wbuf depth 2^wbuf_lg2. WrReady = count < depth, registered from the post-update count.
  - Push and pop in the same cycle leave the count unchanged.
  - WrReq while WrReady=0 is dropped; the writer must hold the request.
- Worst-case read latency: RdReq to first RdValid = 6 cycles if a write has just started, 3 cycles from IDLE.

Optional Feature:
WR_INTERLEAVE_EN
- Defined: during a burst, when the buffer is full after 16 consecutive read words, the arbiter inserts one write (RD_SAMPLE→WR_SETUP→…→WR_HOLD→TURN→RD_ADDR) before resuming the burst. The burst address and count are preserved. This bounds writer stall for long bursts.
- Undefined: writes occur only between bursts and the interleave counter is not synthesized.

Decomposition:
- Shared package vram_pkg: FSM state encoding, default widths (bw_addr, bw_data), and the interleave interval constant (16).
- One natural sub-module, vram_wr_fifo: synchronous FIFO with push, pop, full, empty and count, same Clock and Reset.

Test Plan:
- Reset mid-write: assert Reset during WR_STROBE → nWE=1 within the same cycle, SRAMIO=Z, WrReady=1, no later SRAM write occurs.
- Single burst: RdReq, RdAddr=0x00100, RdLen=4 from IDLE → nOE=0; SRAMAddr steps 0x00100..0x00103 every 2 cycles; 4 RdValid pulses; RdBusy falls with the 4th pulse; first pulse 3 cycles after RdReq.
- Address wrap: RdAddr=0x3FFFE, RdLen=4 → SRAMAddr sequence 3FFFE, 3FFFF, 00000, 00001.
- Write buffer fill: 5 back-to-back WrReq during a 64-word burst (feature off) → 4 accepted, WrReady=0 on the 5th, no nWE pulse until RdBusy=0; then 4 writes of 3 cycles each, in order.
- Contention: burst requested during WR_SETUP of write 0x1234 → write completes, then 1 TURN cycle with SRAMIO=Z and nOE=1, then RD_ADDR; nWE and nOE are never both 0.
- WR_INTERLEAVE_EN defined: buffer full, RdLen=40 → one write inserted after read words 16 and 32; 40 RdValid total, in address order.
